fp_accum: RTL and testbench
===========================

FP_ACCUM -- requirements
Module: fp_accum

Interface
REQ-001: Parameter NUM_TERMS, default 9, is the number of IEEE-754 single products summed per output (kernel window size); legal range 1..255.
REQ-002: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004: in_valid  input  1  in_data holds a valid product this cycle.
REQ-005: in_data  input  32  IEEE-754 single product from the upstream multiplier: sign[31], exponent[30:23], fraction[22:0].
REQ-006: in_ready  output  1  block accepts in_data this cycle.
REQ-007: out_valid  output  1  out_data holds a completed window sum.
REQ-008: out_data  output  32  IEEE-754 single sum of NUM_TERMS accepted products.
REQ-009: out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-010: The FSM SHALL have states ACC, ALIGN, NORM and OUT.
REQ-011: in_ready SHALL be 1 only in ACC; out_valid SHALL be 1 only in OUT.
REQ-012: A term is accepted when in_valid and in_ready are both 1; the FSM then goes ACC->ALIGN.
REQ-013: ALIGN SHALL right-shift the smaller-exponent 24-bit significand (hidden 1 restored) by the exponent difference, truncating shifted-out bits; a difference >= 25 yields 0. It then goes ALIGN->NORM.
REQ-014: NORM SHALL add or subtract the aligned significands by sign, then renormalise in one cycle.
REQ-015: On carry-out, NORM SHALL shift right by 1 and increment the exponent.
REQ-016: Otherwise NORM SHALL shift left by the leading-zero count and decrement the exponent; rounding is truncation only.
REQ-017: After NORM, the term counter SHALL increment; NORM->OUT when the counter equals NUM_TERMS, else NORM->ACC.
REQ-018: Throughput SHALL be one term per 3 cycles; the latency from the last accept to out_valid SHALL be 3 cycles.
REQ-019: Inputs with exponent 0 (zero/denormal) SHALL be treated as signed zero; NaN/Inf encodings are not special-cased.
REQ-020: An exact cancellation SHALL produce +0 (32'h00000000).
REQ-021: A result exponent below 1 SHALL flush to signed zero.
REQ-022: A result exponent above 254 SHALL saturate to exponent 8'hFE with fraction all ones, keeping the sign.
REQ-023: In OUT, out_data and out_valid SHALL hold stable until out_ready is 1.
REQ-024: On the out_ready handshake the accumulator SHALL clear to +0 and the counter to 0, and the FSM goes OUT->ACC; the next term is accepted no earlier than the following cycle.
REQ-025: in_valid while in_ready is 0 SHALL be ignored and SHALL NOT alter state.
REQ-026: With NUM_TERMS=1, out_data SHALL equal the input after zero-flush (sum with +0).

Reset
REQ-027: While reset is 1 at posedge clk: state=ACC, accumulator=+0, counter=0, out_valid=0, out_data=32'h00000000, in_ready=1 after the edge.
REQ-028: Reset SHALL take priority over every handshake; reset mid-window discards partial sums and no out_valid follows for that window.

Configuration
REQ-029: Macro FP_ACCUM_RELU_EN SHALL control a ReLU on the output.
REQ-030: With FP_ACCUM_RELU_EN defined, a final sum with sign 1 SHALL be presented as 32'h00000000 in OUT.
REQ-031: Without FP_ACCUM_RELU_EN, the signed sum SHALL be presented unchanged; no other behaviour differs.

Verification
REQ-032: NUM_TERMS=9, nine 32'h3F800000 (1.0) back-to-back -> out_data=32'h41100000 (9.0); in_ready pattern 1,0,0 repeating; out_valid 3 cycles after the ninth accept.
REQ-033: NUM_TERMS=3, inputs 32'h40000000, 32'hC0000000, 32'h00000000 -> out_data=32'h00000000.
REQ-034: NUM_TERMS=3, inputs 32'h3F800000, 32'h3F800000, 32'hBF800000 -> out_data=32'h3F800000; out_ready held 0 for 5 cycles -> out_data stable and out_valid=1 throughout; accumulator cleared after the handshake.
REQ-035: NUM_TERMS=3, inputs 32'h3F800000, 32'h33800000 (2^-24), 32'h00000000 -> out_data=32'h3F800000 (small term truncated away).
REQ-036: NUM_TERMS=3, sum -1.0 (32'hBF800000): RELU_EN defined -> 32'h00000000; undefined -> 32'hBF800000. Reset asserted after the second accept -> out_valid stays 0; a fresh 3-term window of 32'h3F800000 then gives 32'h40400000.

Source files
------------

// File: rtl/fp_accum.sv
// Iterative IEEE-754 single-precision accumulator: sums NUM_TERMS products per window, one term every 3 cycles.
// Optional output ReLU enabled by defining FP_ACCUM_RELU_EN.
module fp_accum #(
  parameter int NUM_TERMS = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  typedef enum logic [1:0] {ACC, ALIGN, NORM, OUT} state_t;
  state_t state, state_nxt;

  logic        acc_sign;
  logic [7:0]  acc_exp;
  logic [23:0] acc_man;
  logic [7:0]  cnt;

  logic        t_sign_p0;
  logic [7:0]  t_exp_p0;
  logic [23:0] t_man_p0;

  logic        big_sign_p1, small_sign_p1;
  logic [7:0]  exp_p1;
  logic [23:0] big_man_p1, small_man_p1;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc24 = 5'(23 - i);
  endfunction

  // Flush underflow to signed zero, clamp overflow to the largest finite magnitude.
  function automatic logic [32:0] saturate(input logic sign, input logic signed [9:0] e,
                                           input logic [23:0] man);
    if (e < 10'sd1)        saturate = {sign, 8'd0, 24'd0};
    else if (e > 10'sd254) saturate = {sign, 8'hFE, 24'hFFFFFF};
    else                   saturate = {sign, e[7:0], man};
  endfunction

  function automatic logic [32:0] normalize(input logic sign, input logic [7:0] exp_in,
                                            input logic [24:0] sum, input logic mixed);
    logic signed [9:0] e;
    logic [4:0]        lz;
    e = signed'({2'b00, exp_in});
    if (sum == 25'd0) begin
      normalize = {(mixed ? 1'b0 : sign), 8'd0, 24'd0};
    end else if (sum[24]) begin
      normalize = saturate(sign, e + 10'sd1, sum[24:1]);
    end else begin
      lz = lzc24(sum[23:0]);
      normalize = saturate(sign, e - signed'({5'd0, lz}), sum[23:0] << lz);
    end
  endfunction

  function automatic logic [31:0] pack(input logic sign, input logic [7:0] e, input logic [23:0] man);
    if (e == 8'd0) pack = {sign, 31'd0};
    else           pack = {sign, e, man[22:0]};
`ifdef FP_ACCUM_RELU_EN
    if (pack[31]) pack = 32'h00000000;
`endif
  endfunction

  // Alignment: the accumulator is treated as the larger operand on an exponent tie.
  logic        acc_big;
  logic [7:0]  exp_diff;
  logic [23:0] small_pre, small_aligned;

  always_comb begin
    acc_big       = (acc_exp >= t_exp_p0);
    exp_diff      = acc_big ? (acc_exp - t_exp_p0) : (t_exp_p0 - acc_exp);
    small_pre     = acc_big ? t_man_p0 : acc_man;
    small_aligned = (exp_diff >= 8'd25) ? 24'd0 : (small_pre >> exp_diff);
  end

  logic        sum_sign, mixed;
  logic [24:0] sum_mag;
  logic [32:0] norm_res;
  logic [7:0]  cnt_inc;
  logic        last_term;

  always_comb begin
    mixed = (big_sign_p1 != small_sign_p1);
    if (!mixed) begin
      sum_mag  = {1'b0, big_man_p1} + {1'b0, small_man_p1};
      sum_sign = big_sign_p1;
    end else if (big_man_p1 >= small_man_p1) begin
      sum_mag  = {1'b0, big_man_p1} - {1'b0, small_man_p1};
      sum_sign = big_sign_p1;
    end else begin
      sum_mag  = {1'b0, small_man_p1} - {1'b0, big_man_p1};
      sum_sign = small_sign_p1;
    end
    norm_res  = normalize(sum_sign, exp_p1, sum_mag, mixed);
    cnt_inc   = cnt + 8'd1;
    last_term = (cnt_inc == 8'(NUM_TERMS));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (in_valid) state_nxt = ALIGN;
      ALIGN:   state_nxt = NORM;
      NORM:    state_nxt = last_term ? OUT : ACC;
      OUT:     if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);

  // Stage p0: capture the accepted term, zero/denormal inputs become signed zero.
  always_ff @(posedge clk) begin
    if (state == ACC && in_valid) begin
      t_sign_p0 <= in_data[31];
      t_exp_p0  <= in_data[30:23];
      t_man_p0  <= (in_data[30:23] == 8'd0) ? 24'd0 : {1'b1, in_data[22:0]};
    end
  end

  // Stage p1: aligned operands for the add/subtract.
  always_ff @(posedge clk) begin
    if (state == ALIGN) begin
      big_sign_p1   <= acc_big ? acc_sign : t_sign_p0;
      small_sign_p1 <= acc_big ? t_sign_p0 : acc_sign;
      exp_p1        <= acc_big ? acc_exp : t_exp_p0;
      big_man_p1    <= acc_big ? acc_man : t_man_p0;
      small_man_p1  <= small_aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACC;
      acc_sign <= 1'b0;
      acc_exp  <= 8'd0;
      acc_man  <= 24'd0;
      cnt      <= 8'd0;
      out_data <= 32'h00000000;
    end else begin
      state <= state_nxt;
      if (state == NORM) begin
        {acc_sign, acc_exp, acc_man} <= norm_res;
        cnt <= cnt_inc;
        if (last_term) out_data <= pack(norm_res[32], norm_res[31:24], norm_res[23:0]);
      end else if (state == OUT && out_ready) begin
        acc_sign <= 1'b0;
        acc_exp  <= 8'd0;
        acc_man  <= 24'd0;
        cnt      <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum: a 9-term instance for timing, a 3-term instance for arithmetic corners.
// Expected values follow FP_ACCUM_RELU_EN when that macro is defined for the build.
module tb_fp_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v9 = 1'b0, r9, ov9, or9 = 1'b0;
  logic [31:0] d9 = 32'h0, od9;
  logic        v3 = 1'b0, r3, ov3, or3 = 1'b0;
  logic [31:0] d3 = 32'h0, od3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_accum #(.NUM_TERMS(9)) dut9 (
    .clk(clk), .reset(rst), .in_valid(v9), .in_data(d9), .in_ready(r9),
    .out_valid(ov9), .out_data(od9), .out_ready(or9)
  );

  fp_accum #(.NUM_TERMS(3)) dut3 (
    .clk(clk), .reset(rst), .in_valid(v3), .in_data(d3), .in_ready(r3),
    .out_valid(ov3), .out_data(od3), .out_ready(or3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one term to dut3; with junk set, in_valid stays high carrying garbage while busy.
  task automatic send3(input logic [31:0] d, input bit junk);
    int k = 0;
    while (!r3 && k < 20) begin
      step();
      k++;
    end
    if (!r3) check("send_ready_timeout", {31'd0, r3}, 32'd1);
    v3 = 1'b1;
    d3 = d;
    step();
    if (junk) d3 = 32'h44790000;
    else v3 = 1'b0;
  endtask

  task automatic wait_out3();
    int k = 0;
    v3 = 1'b0;
    while (!ov3 && k < 20) begin
      step();
      k++;
    end
    check("out_valid_seen", {31'd0, ov3}, 32'd1);
  endtask

  task automatic handshake3();
    or3 = 1'b1;
    step();
    or3 = 1'b0;
    check("ov_after_handshake", {31'd0, ov3}, 32'd0);
  endtask

  task automatic window3(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] exp);
    send3(a, 1'b0);
    send3(b, 1'b0);
    send3(c, 1'b0);
    wait_out3();
    check(tag, od3, exp);
    handshake3();
  endtask

  logic [31:0] relu_exp;
  bit          seen;

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, r3}, 32'd1);
    check("rst_out_valid", {31'd0, ov3}, 32'd0);
    check("rst_out_data", od3, 32'h00000000);
    check("rst_out_data9", od9, 32'h00000000);

    // Nine 1.0 terms back to back: ready pattern 1,0,0 and out_valid three cycles after the last accept.
    for (int i = 0; i < 9; i++) begin
      check("r9_accept", {31'd0, r9}, 32'd1);
      v9 = 1'b1;
      d9 = 32'h3F800000;
      step();
      v9 = 1'b0;
      check("r9_busy1", {31'd0, r9}, 32'd0);
      check("ov9_busy1", {31'd0, ov9}, 32'd0);
      step();
      check("r9_busy2", {31'd0, r9}, 32'd0);
      check("ov9_busy2", {31'd0, ov9}, 32'd0);
      step();
    end
    check("ov9_latency", {31'd0, ov9}, 32'd1);
    check("r9_in_out", {31'd0, r9}, 32'd0);
    check("sum9", od9, 32'h41100000);
    or9 = 1'b1;
    step();
    or9 = 1'b0;
    check("ov9_cleared", {31'd0, ov9}, 32'd0);
    check("r9_back", {31'd0, r9}, 32'd1);

    window3("cancel", 32'h40000000, 32'hC0000000, 32'h00000000, 32'h00000000);

    // Busy-time in_valid carries garbage that must be ignored; output holds under backpressure.
    send3(32'h3F800000, 1'b1);
    send3(32'h3F800000, 1'b1);
    send3(32'hBF800000, 1'b1);
    wait_out3();
    check("sum_1_1_m1", od3, 32'h3F800000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {31'd0, ov3}, 32'd1);
      check("hold_data", od3, 32'h3F800000);
    end
    handshake3();
    window3("acc_cleared", 32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000);

    window3("truncate_small", 32'h3F800000, 32'h33800000, 32'h00000000, 32'h3F800000);
    window3("saturate", 32'h7F000000, 32'h7F000000, 32'h00000000, 32'h7F7FFFFF);
`ifdef FP_ACCUM_RELU_EN
    relu_exp = 32'h00000000;
`else
    relu_exp = 32'h80000000;
`endif
    window3("underflow_flush", 32'h80C00000, 32'h00800000, 32'h80000000, relu_exp);
`ifdef FP_ACCUM_RELU_EN
    relu_exp = 32'h00000000;
`else
    relu_exp = 32'hBF800000;
`endif
    window3("neg_sum", 32'hBF800000, 32'h00000000, 32'h00000000, relu_exp);

    // Reset mid-window discards the partial sum.
    send3(32'h3F800000, 1'b0);
    send3(32'h3F800000, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ready", {31'd0, r3}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ov3) seen = 1'b1;
    end
    check("midrst_no_valid", {31'd0, seen}, 32'd0);
    window3("after_reset", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
